// File: rtl/alu_seq_shifter_if.sv
// Start/done handshake bundle between the execute-stage
// controller and the multi-cycle shifter.
interface alu_seq_shifter_if;
  logic        start;
  logic [15:0] in;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport master (
    output start, in, op, amt,
    input  busy, done, out
  );

  modport slave (
    input  start, in, op, amt,
    output busy, done, out
  );
endinterface

// File: rtl/alu_seq_shifter.sv
// Multi-cycle 16-bit shift/rotate unit: one 4-bit or
// 1-bit step per clock, framed by a start/done handshake.
module alu_seq_shifter (
  input  logic        clk,
  input  logic        rst,
  alu_seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [15:0] data, data_n;
  logic [1:0]  op_r, op_n;
  logic [3:0]  rem, rem_n;
  logic        big;

  function automatic logic [15:0] step(
    input logic [15:0] d,
    input logic [1:0]  op,
    input logic        four
  );
    logic [15:0] r;
    r = d;
    unique case (1'b1)
      (op == 2'b00 &&  four): r = {d[11:0], d[15:12]};
      (op == 2'b01 &&  four): r = {d[11:0], 4'h0};
      (op == 2'b10 &&  four): r = {d[3:0], d[15:4]};
      (op == 2'b11 &&  four): r = {4'h0, d[15:4]};
      (op == 2'b00 && !four): r = {d[14:0], d[15]};
      (op == 2'b01 && !four): r = {d[14:0], 1'b0};
      (op == 2'b10 && !four): r = {d[0], d[15:1]};
      (op == 2'b11 && !four): r = {1'b0, d[15:1]};
      default:                r = d;
    endcase
    return r;
  endfunction

  assign big = (rem >= 4'd4);

  always_comb begin
    state_n = state;
    data_n  = data;
    op_n    = op_r;
    rem_n   = rem;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = SHIFT;
          data_n  = bus.in;
          op_n    = bus.op;
          rem_n   = bus.amt;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (rem == 4'd0) begin
          state_n = DONE;
        end else begin
          data_n = step(data, op_r, big);
          rem_n  = big ? rem - 4'd4 : rem - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= 16'h0000;
      op_r  <= 2'b00;
      rem   <= 4'd0;
    end else begin
      state <= state_n;
      data  <= data_n;
      op_r  <= op_n;
      rem   <= rem_n;
    end
  end

  // Outputs decode registered state only.
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.out  = data;

endmodule

// File: tb/tb_alu_seq_shifter.sv
// Directed bench for alu_seq_shifter: hand vectors, handshake
// corner cases and a full op x amount sweep against a model.
module tb_alu_seq_shifter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_seq_shifter_if bus ();

  alu_seq_shifter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x,
                                        input logic [1:0]  op,
                                        input int          a);
    logic [31:0] w;
    w = {16'h0, x};
    case (op)
      2'b00: return 16'(((w << a) | (w >> (16 - a))) & 32'hFFFF);
      2'b01: return 16'((w << a) & 32'hFFFF);
      2'b10: return 16'(((w >> a) | (w << (16 - a))) & 32'hFFFF);
      default: return 16'(w >> a);
    endcase
  endfunction

  // Accept on the next edge (E0), then count edges until done.
  task automatic run_op(input string tag,
                        input logic [15:0] din,
                        input logic [1:0]  op,
                        input logic [3:0]  amt,
                        input logic [15:0] exp,
                        input int          lat);
    int n;
    logic bad_busy;
    bus.start = 1'b1;
    bus.in    = din;
    bus.op    = op;
    bus.amt   = amt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in    = 16'($urandom);
    n = 0;
    bad_busy = 1'b0;
    while (!bus.done && n < 20) begin
      if (!bus.busy) bad_busy = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_busy"}, {31'h0, bad_busy}, 32'h0);
    check({tag, "_lat"}, n, lat);
    check({tag, "_out"}, {16'h0, bus.out}, {16'h0, exp});
    @(posedge clk); #1;
    check({tag, "_donepulse"}, {31'h0, bus.done}, 32'h0);
  endtask

  initial begin
    int n;
    logic saw_done;
    logic [15:0] v;
    checks = 0;
    errors = 0;

    // Reset with random inputs.
    rst       = 1'b1;
    bus.start = 1'($urandom);
    bus.in    = 16'($urandom);
    bus.op    = 2'($urandom);
    bus.amt   = 4'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {16'h0, bus.out}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", {31'h0, bus.busy}, 32'h0);
    check("idle_done", {31'h0, bus.done}, 32'h0);
    check("idle_out", {16'h0, bus.out}, 32'h0);

    // Directed vectors, latency = steps + 1.
    run_op("rol4", 16'h1234, 2'b00, 4'd4, 16'h2341, 2);
    run_op("sll5", 16'hFFFF, 2'b01, 4'd5, 16'hFFE0, 3);
    run_op("srl15", 16'h8000, 2'b11, 4'd15, 16'h0001, 7);
    run_op("ror8", 16'h00FF, 2'b10, 4'd8, 16'hFF00, 3);
    run_op("zero0", 16'hBEEF, 2'b00, 4'd0, 16'hBEEF, 1);
    run_op("zero3", 16'hBEEF, 2'b11, 4'd0, 16'hBEEF, 1);

    // Start during SHIFT is ignored.
    bus.start = 1'b1;
    bus.in    = 16'h1234;
    bus.op    = 2'b00;
    bus.amt   = 4'd15;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.in    = 16'hFFFF;
    bus.op    = 2'b01;
    bus.amt   = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 2;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ign_lat", n, 7);
    check("ign_out", {16'h0, bus.out}, 32'h091A);

    // Back-to-back: start held in the DONE cycle.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.in    = 16'h00F0;
    bus.op    = 2'b11;
    bus.amt   = 4'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_a_lat", n, 2);
    check("b2b_a_out", {16'h0, bus.out}, 32'h000F);
    bus.start = 1'b1;
    bus.in    = 16'h0001;
    bus.op    = 2'b00;
    bus.amt   = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_done_drop", {31'h0, bus.done}, 32'h0);
    check("b2b_busy", {31'h0, bus.busy}, 32'h1);
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_b_lat", n, 2);
    check("b2b_b_out", {16'h0, bus.out}, 32'h0002);
    @(posedge clk); #1;

    // Sweep every op and amount against the model.
    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 16; a++) begin
        v = 16'($urandom);
        run_op($sformatf("sw_o%0d_a%0d", o, a), v, 2'(o), 4'(a),
               model(v, 2'(o), a), (a / 4) + (a % 4) + 1);
      end
    end

    // Reset in the middle of an amt=15 operation.
    bus.start = 1'b1;
    bus.in    = 16'hA5A5;
    bus.op    = 2'b10;
    bus.amt   = 4'd15;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out", {16'h0, bus.out}, 32'h0);
    check("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("mid_rst_done", {31'h0, bus.done}, 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("mid_rst_nodone", {31'h0, saw_done}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_shifter.md
# alu_seq_shifter

Multi-cycle shift/rotate unit for the ALU. It shifts or rotates a 16-bit operand by 0–15 positions using one 4-bit step or one 1-bit step per clock. It serves the power-saving and multi-cycle execute path, and must match the single-cycle ALU shifter result for every op and amount. A start/done handshake with the execute-stage controller frames each operation.

## Interface
- No parameters. Data width is fixed at 16 bits and shift amount at 4 bits.
- clk — input, 1 — system clock; all state updates on the rising edge.
- rst — input, 1 — synchronous, active-high reset.
- start — input, 1 — request; sampled only when the block is ready (state IDLE or DONE).
- in — input, 16 — operand; captured on the accepting edge.
- op — input, 2 — operation, captured with in:
  - 00 rotate left
  - 01 shift left logical
  - 10 rotate right
  - 11 shift right logical
- amt — input, 4 — shift count 0–15; captured with in.
- busy — output, 1 — high while state is SHIFT.
- done — output, 1 — one-cycle pulse; high while state is DONE.
- out — output, 16 — result register; valid when done=1 and held until the next accepting edge.

## Operation
- Registers:
  - state (IDLE/SHIFT/DONE)
  - data[15:0], which drives out
  - op_r[1:0]
  - rem[3:0]
- IDLE or DONE with start=1 → load data=in, op_r=op, rem=amt; go to SHIFT.
- IDLE with start=0 → stay in IDLE.
- DONE with start=0 → go to IDLE.
- SHIFT, one action per edge:
  - rem≥4: apply a 4-position step of op_r to data; rem −= 4.
  - 1≤rem≤3: apply a 1-position step of op_r to data; rem −= 1.
  - rem=0: data unchanged; go to DONE.
- Step semantics for a k-position step:
  - Rotate: bits leaving one end enter the other.
  - Logical shift: vacated positions fill with 0.
  - There is no arithmetic shift; sign is not preserved.
- start while in SHIFT is ignored. in, op and amt may change freely during SHIFT with no effect.
- out shows intermediate values during SHIFT. Consumers must qualify out with done.
- amt=0 → result equals in, after the normal SHIFT→DONE pass (no bypass).
- rst=1 at any edge, including mid-operation:
  - state=IDLE, data=0x0000, op_r=00, rem=0, busy=0, done=0.
  - Any in-flight operation is discarded and produces no done pulse.
  - rst has priority over start.

## Timing
- E0 is the accepting edge. steps = amt[3:2] + amt[1:0].
- SHIFT lasts steps+1 cycles; busy is high during those cycles.
- done rises after edge E0+steps+1 and stays high for exactly one cycle.
- Latency examples:
  - amt=0: done after E1.
  - amt=4: done after E2.
  - amt=15: done after E7 (the worst case).
- Back-to-back: start=1 during the DONE cycle is accepted on that edge. The state returns to SHIFT with no IDLE bubble, and done drops on that edge.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs → out=0x0000, busy=0, done=0; after release, IDLE holds with start=0.
- Rotate left: in=0x1234, op=00, amt=4 → busy for 2 cycles; done after E2 with out=0x2341.
- Logical shifts:
  - in=0xFFFF, op=01, amt=5 → out=0xFFE0, done after E3.
  - in=0x8000, op=11, amt=15 → out=0x0001, done after E7.
- Rotate right and zero amount:
  - in=0x00FF, op=10, amt=8 → out=0xFF00, done after E3.
  - in=0xBEEF, amt=0, any op → out=0xBEEF, done after E1.
- Handshake:
  - start pulsed during SHIFT with different operands → ignored; the original result completes.
  - start=1 in the DONE cycle → the second operation begins immediately.
  - Sweep all 4 ops × 16 amounts against a reference model.
- Reset mid-operation: assert rst at E3 of an amt=15 operation → next cycle out=0, busy=0, and no done pulse is ever produced.
